xbram_tdp_ctrl: RTL



---
 rtl/xbram_pkg.sv | 22 ++
 rtl/xbram_rd_pipe.sv | 43 ++++
 rtl/xbram_tdp_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/xbram_pkg.sv
// Shared definitions for the true-dual-port BRAM controller: state encoding,
// latency limits, collision counter width and an address-width helper.
package xbram_pkg;

   localparam int READ_LATENCY_MIN = 1;
   localparam int READ_LATENCY_MAX = 4;
   localparam int COLL_CNT_WIDTH   = 16;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   // Never returns less than 1 so a single-word array still gets a real address port.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return (result < 1) ? 1 : result;
   endfunction

endpackage

// File: rtl/xbram_rd_pipe.sv
// Read-return shift register: a valid bit and a data word travel LATENCY stages;
// data stages only load behind a valid so the output word holds between reads.
module xbram_rd_pipe
   import xbram_pkg::*;
#(
   parameter int LATENCY    = 2,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data
);

   localparam int STAGES = (LATENCY < READ_LATENCY_MIN) ? READ_LATENCY_MIN :
                           (LATENCY > READ_LATENCY_MAX) ? READ_LATENCY_MAX : LATENCY;

   logic                  vld [STAGES];
   logic [DATA_WIDTH-1:0] dat [STAGES];

   // Reset flushes every stage so nothing issued before reset can come back out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            vld[i] <= 1'b0;
            dat[i] <= '0;
         end
      end else begin
         vld[0] <= in_valid;
         if (in_valid) dat[0] <= in_data;
         for (int i = 1; i < STAGES; i++) begin
            vld[i] <= vld[i-1];
            if (vld[i-1]) dat[i] <= dat[i-1];
         end
      end
   end

   assign out_valid = vld[STAGES-1];
   assign out_data  = dat[STAGES-1];

endmodule

// File: rtl/xbram_tdp_ctrl.sv
// True-dual-port RAM controller: valid/ready ports, byte-enable writes, write-first
// collision handling, collision counting and an optional post-reset array clear.
module xbram_tdp_ctrl
   import xbram_pkg::*;
#(
   parameter int DEPTH        = 1024,
   parameter int DATA_WIDTH   = 32,
   parameter int BYTE_WIDTH   = 8,
   parameter int READ_LATENCY = 2,
   parameter int INIT_CLEAR   = 1,
   parameter int ADDR_WIDTH   = clog2(DEPTH),
   parameter int NBYTES       = DATA_WIDTH / BYTE_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      a_valid,
   output logic                      a_ready,
   input  logic                      a_we,
   input  logic [NBYTES-1:0]         a_be,
   input  logic [ADDR_WIDTH-1:0]     a_addr,
   input  logic [DATA_WIDTH-1:0]     a_wdata,
   output logic                      a_rvalid,
   output logic [DATA_WIDTH-1:0]     a_rdata,
   input  logic                      b_valid,
   output logic                      b_ready,
   input  logic                      b_we,
   input  logic [NBYTES-1:0]         b_be,
   input  logic [ADDR_WIDTH-1:0]     b_addr,
   input  logic [DATA_WIDTH-1:0]     b_wdata,
   output logic                      b_rvalid,
   output logic [DATA_WIDTH-1:0]     b_rdata,
   output logic                      init_done,
   output logic                      coll_pulse,
   output logic [COLL_CNT_WIDTH-1:0] coll_cnt
);

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   clr_addr;
   logic                    a_acc, b_acc, a_inr, b_inr, a_wr, b_wr, coll;
   logic [DATA_WIDTH-1:0]   a_rword, b_rword;
   logic                    a_rq_v, b_rq_v;
   logic [DATA_WIDTH-1:0]   a_rq_d, b_rq_d;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   assign a_acc = a_valid & a_ready;
   assign b_acc = b_valid & b_ready;
   assign a_inr = (32'(a_addr) < DEPTH);
   assign b_inr = (32'(b_addr) < DEPTH);
   assign a_wr  = a_acc & a_we & a_inr;
   assign b_wr  = b_acc & b_we & b_inr;
   assign coll  = a_wr & b_wr & (a_addr == b_addr);

   // Ports stay closed until the clear sweep finishes; the readies are the FSM's registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;
         clr_addr  <= '0;
         a_ready   <= 1'b0;
         b_ready   <= 1'b0;
         init_done <= 1'b0;
      end else begin
         case (state)
            ST_CLEAR: begin
               if (clr_addr == ADDR_WIDTH'(DEPTH - 1)) begin
                  state     <= ST_RUN;
                  a_ready   <= 1'b1;
                  b_ready   <= 1'b1;
                  init_done <= 1'b1;
               end else begin
                  clr_addr <= clr_addr + 1'b1;
               end
            end
            ST_RUN: begin
               a_ready   <= 1'b1;
               b_ready   <= 1'b1;
               init_done <= 1'b1;
            end
            default: state <= ST_RUN;
         endcase
      end
   end

   // B lanes are written first so that lanes enabled by both ports end up with A's data.
   always_ff @(posedge clk) begin
      if (state == ST_CLEAR) mem[clr_addr] <= '0;
      for (int i = 0; i < NBYTES; i++) begin
         if (b_wr && b_be[i]) mem[b_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= b_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
         if (a_wr && a_be[i]) mem[a_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= a_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
   end

   // Write-first: a read sees the other port's same-cycle write merged over the stored word.
   always_comb begin
      a_rword = a_inr ? mem[a_addr] : '0;
      b_rword = b_inr ? mem[b_addr] : '0;
      for (int i = 0; i < NBYTES; i++) begin
         if (b_wr && (b_addr == a_addr) && b_be[i])
            a_rword[i*BYTE_WIDTH +: BYTE_WIDTH] = b_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
         if (a_wr && (a_addr == b_addr) && a_be[i])
            b_rword[i*BYTE_WIDTH +: BYTE_WIDTH] = a_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
   end

   // Array read register followed by the latency pipe; together they place rvalid
   // READ_LATENCY edges after the accepting edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_rq_v     <= 1'b0;
         b_rq_v     <= 1'b0;
         a_rq_d     <= '0;
         b_rq_d     <= '0;
         coll_pulse <= 1'b0;
         coll_cnt   <= '0;
      end else begin
         a_rq_v     <= a_acc & ~a_we;
         b_rq_v     <= b_acc & ~b_we;
         if (a_acc && !a_we) a_rq_d <= a_rword;
         if (b_acc && !b_we) b_rq_d <= b_rword;
         coll_pulse <= coll;
         if (coll && (coll_cnt != '1)) coll_cnt <= coll_cnt + 1'b1;
      end
   end

   xbram_rd_pipe #(
      .LATENCY    (READ_LATENCY),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_pipe_a (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (a_rq_v),
      .in_data   (a_rq_d),
      .out_valid (a_rvalid),
      .out_data  (a_rdata)
   );

   xbram_rd_pipe #(
      .LATENCY    (READ_LATENCY),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_pipe_b (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (b_rq_v),
      .in_data   (b_rq_d),
      .out_valid (b_rvalid),
      .out_data  (b_rdata)
   );

endmodule
